// File: rtl/regwrite_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// FSM state encoding, requester count, select width and a one-hot helper.
package regwrite_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Expand a requester index into a one-hot acknowledge vector.
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_picker4.sv
// Combinational 4-way winner picker. Searches upward from ptr_i (wrapping
// 3->0) for the first active request; in fixed-priority mode the search
// always starts at index 0, so the lowest index wins.
module rr_picker4
    import regwrite_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    input  logic               prio_mode_i,
    output logic [SEL_W-1:0]   grant_idx_o,
    output logic               grant_vld_o
);

    logic [SEL_W-1:0] start;
    logic [SEL_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest active request
    // is the last one assigned and therefore wins.
    always_comb begin
        start       = prio_mode_i ? '0 : ptr_i;
        cand        = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (req_i[cand]) begin
                grant_idx_o = cand;
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regwrite_port_arbiter.sv
// Register-file write-port arbiter: shares one write port among four
// write-back requesters (ALU, load, link, stack). A two-state FSM picks a
// winner in IDLE, latches its address/data, and issues a single registered
// write cycle in WRITE with a one-hot ack pulse.
// Optional build macro ZERO_REG_FILTER_EN: a winner targeting register 0 is
// still acknowledged, but the write strobe is suppressed.
module regwrite_port_arbiter
    import regwrite_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int PRIO_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      wr_en_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic                      busy_o
);

    localparam logic PRIO_FIXED = (PRIO_MODE != 0);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    rr_picker4 u_picker (
        .req_i       (req_i),
        .ptr_i       (rr_ptr_q),
        .prio_mode_i (PRIO_FIXED),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    // Steer the winner's destination and data out of the packed buses.
    always_comb begin
        win_addr = addr_i[grant_idx*ADDR_W +: ADDR_W];
        win_data = data_i[grant_idx*DATA_W +: DATA_W];
    end

    // Next-state and registered-output logic; strobes default low so they
    // last exactly one cycle, while sel/addr/data hold the last winner.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ack_d    = '0;
        wr_en_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d = ST_WRITE;
                    sel_d   = grant_idx;
                    addr_d  = win_addr;
                    data_d  = win_data;
                    ack_d   = idx_to_onehot(grant_idx);
                    busy_d  = 1'b1;
`ifdef ZERO_REG_FILTER_EN
                    wr_en_d = (win_addr != '0);
`else
                    wr_en_d = 1'b1;
`endif
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
                // Next search starts just past the requester served now;
                // fixed priority leaves the pointer parked at 0.
                if (!PRIO_FIXED) begin
                    rr_ptr_d = sel_q + SEL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers; async reset aborts any write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            ack_q    <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            ack_q    <= ack_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

    assign ack_o     = ack_q;
    assign sel_o     = sel_q;
    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_regwrite_port_arbiter.sv
// Directed bench for regwrite_port_arbiter: a round-robin instance and a
// fixed-priority instance share clock, reset, address and data buses, each
// with its own request vector.
module tb_regwrite_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

`ifdef ZERO_REG_FILTER_EN
    localparam logic EXP_ZERO_WE = 1'b0;
`else
    localparam logic EXP_ZERO_WE = 1'b1;
`endif

    logic          clk;
    logic          reset_n;
    logic [3:0]    req_rr, req_fp;
    logic [4*AW-1:0] addr_bus;
    logic [4*DW-1:0] data_bus;

    logic [3:0]    ack_rr, ack_fp;
    logic [1:0]    sel_rr, sel_fp;
    logic          we_rr, we_fp;
    logic [AW-1:0] wa_rr, wa_fp;
    logic [DW-1:0] wd_rr, wd_fp;
    logic          busy_rr, busy_fp;

    int n_cmp = 0;
    int n_bad = 0;

    regwrite_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req_rr), .addr_i(addr_bus), .data_i(data_bus),
        .ack_o(ack_rr), .sel_o(sel_rr), .wr_en_o(we_rr), .wr_addr_o(wa_rr),
        .wr_data_o(wd_rr), .busy_o(busy_rr)
    );

    regwrite_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .reset_n(reset_n), .req_i(req_fp), .addr_i(addr_bus), .data_i(data_bus),
        .ack_o(ack_fp), .sel_o(sel_fp), .wr_en_o(we_fp), .wr_addr_o(wa_fp),
        .wr_data_o(wd_fp), .busy_o(busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int k, input logic [AW-1:0] a);
        addr_bus[k*AW +: AW] = a;
    endtask

    initial begin
        reset_n  = 1'b0;
        req_rr   = 4'b0000;
        req_fp   = 4'b0000;
        addr_bus = '0;
        data_bus = {32'h3333_0003, 32'hDEAD_BEEF, 32'h2222_0001, 32'h1111_0000};
        set_addr(0, 5'd5);
        set_addr(1, 5'd7);
        set_addr(2, 5'd9);
        set_addr(3, 5'd30);
        tick();
        tick();

        // Reset values
        chk("rst_wr_en", 32'(we_rr), 32'h0);
        chk("rst_ack", 32'(ack_rr), 32'h0);
        chk("rst_sel", 32'(sel_rr), 32'h0);
        chk("rst_addr", 32'(wa_rr), 32'h0);
        chk("rst_data", wd_rr, 32'h0);
        chk("rst_busy", 32'(busy_rr), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("idle_no_req_ack", 32'(ack_rr), 32'h0);

        // Single request from requester 2
        req_rr = 4'b0100;
        req_fp = 4'b0100;
        tick();
        chk("single_wr_en", 32'(we_rr), 32'h1);
        chk("single_sel", 32'(sel_rr), 32'h2);
        chk("single_addr", 32'(wa_rr), 32'd9);
        chk("single_data", wd_rr, 32'hDEAD_BEEF);
        chk("single_ack", 32'(ack_rr), 32'b0100);
        chk("single_busy", 32'(busy_rr), 32'h1);
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        tick();
        chk("post_wr_en", 32'(we_rr), 32'h0);
        chk("post_ack", 32'(ack_rr), 32'h0);
        chk("post_busy", 32'(busy_rr), 32'h0);
        chk("post_sel_hold", 32'(sel_rr), 32'h2);
        chk("post_addr_hold", 32'(wa_rr), 32'd9);
        chk("post_data_hold", wd_rr, 32'hDEAD_BEEF);

        // Wrap: round-robin pointer now 3, requests 0 and 3 pending
        req_rr = 4'b1001;
        req_fp = 4'b1001;
        tick();
        chk("wrap_rr_ack1", 32'(ack_rr), 32'b1000);
        chk("wrap_rr_sel1", 32'(sel_rr), 32'h3);
        chk("wrap_rr_addr1", 32'(wa_rr), 32'd30);
        chk("wrap_rr_data1", wd_rr, 32'h3333_0003);
        chk("wrap_fp_ack1", 32'(ack_fp), 32'b0001);
        chk("wrap_fp_addr1", 32'(wa_fp), 32'd5);
        req_rr = 4'b0001;
        req_fp = 4'b1000;
        tick();
        chk("wrap_rr_gap", 32'(ack_rr), 32'h0);
        chk("wrap_fp_gap", 32'(ack_fp), 32'h0);
        tick();
        chk("wrap_rr_ack2", 32'(ack_rr), 32'b0001);
        chk("wrap_rr_sel2", 32'(sel_rr), 32'h0);
        chk("wrap_fp_ack2", 32'(ack_fp), 32'b1000);
        chk("wrap_fp_sel2", 32'(sel_fp), 32'h3);
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        tick();

        // Asynchronous reset mid-run clears latched outputs immediately
        set_addr(0, 5'd5);
        req_rr = 4'b0010;
        tick();
        chk("pre_rst_sel", 32'(sel_rr), 32'h1);
        req_rr = 4'b0000;
        tick();
        reset_n = 1'b0;
        #2;
        chk("async_rst_sel", 32'(sel_rr), 32'h0);
        chk("async_rst_addr", 32'(wa_rr), 32'h0);
        chk("async_rst_data", wd_rr, 32'h0);
        chk("async_rst_fp_sel", 32'(sel_fp), 32'h0);
        reset_n = 1'b1;

        // Round-robin fairness with all requesters held
        req_rr = 4'b1111;
        req_fp = 4'b1111;
        tick();
        chk("rr_ack0", 32'(ack_rr), 32'b0001);
        chk("fp_ack_all0", 32'(ack_fp), 32'b0001);
        tick();
        chk("rr_gap0", 32'(ack_rr), 32'h0);
        tick();
        chk("rr_ack1", 32'(ack_rr), 32'b0010);
        chk("fp_ack_all1", 32'(ack_fp), 32'b0001);
        tick();
        chk("rr_gap1", 32'(busy_rr), 32'h0);
        tick();
        chk("rr_ack2", 32'(ack_rr), 32'b0100);
        tick();
        tick();
        chk("rr_ack3", 32'(ack_rr), 32'b1000);
        tick();
        tick();
        chk("rr_ack4", 32'(ack_rr), 32'b0001);
        req_rr = 4'b0000;
        req_fp = 4'b0000;
        tick();

        // Abort: reset during WRITE, held request re-issued after release
        req_rr = 4'b0100;
        tick();
        chk("abort_pre_ack", 32'(ack_rr), 32'b0100);
        reset_n = 1'b0;
        #1;
        chk("abort_ack", 32'(ack_rr), 32'h0);
        chk("abort_wr_en", 32'(we_rr), 32'h0);
        chk("abort_busy", 32'(busy_rr), 32'h0);
        tick();
        chk("abort_hold_ack", 32'(ack_rr), 32'h0);
        reset_n = 1'b1;
        tick();
        chk("abort_reack", 32'(ack_rr), 32'b0100);
        chk("abort_reack_we", 32'(we_rr), 32'h1);
        req_rr = 4'b0000;
        tick();

        // Write to register 0
        set_addr(0, 5'd0);
        req_rr = 4'b0001;
        tick();
        chk("zero_ack", 32'(ack_rr), 32'b0001);
        chk("zero_addr", 32'(wa_rr), 32'h0);
        chk("zero_wr_en", 32'(we_rr), 32'(EXP_ZERO_WE));
        chk("zero_busy", 32'(busy_rr), 32'h1);
        req_rr = 4'b0000;
        tick();
        chk("zero_after_we", 32'(we_rr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
